// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// The loader owns the master side; the IMEM write port is the slave.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_imem_loader.sv
// UART (8N1) program loader: receives a length-prefixed image and writes it into IMEM,
// holding the CPU in reset meanwhile. Define LOADER_CSUM_EN to expect a trailing XOR checksum byte.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rxd,
  input  logic                start,
  uart_imem_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int          CW      = $clog2(CLKS_PER_BIT);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

  // ---------------- RX front end ----------------
  rx_state_t       rx_state;
  logic            rxd_s1, rxd_s2, rxd_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            frame_err;

  // NOTE: every register below updates with <= so all flops see pre-edge values, like real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1     <= 1'b1;
      rxd_s2     <= 1'b1;
      rxd_prev   <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_s1     <= rxd;
      rxd_s2     <= rxd_s1;
      rxd_prev   <= rxd_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rxd_prev && !rxd_s2) begin
          cnt      <= CW'(CLKS_PER_BIT / 2 - 1);
          rx_state <= RX_START;
        end
        RX_START: if (cnt == '0) begin
          // A line already high again at mid start bit was only a glitch.
          rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
          cnt      <= CW'(CLKS_PER_BIT - 1);
          bit_idx  <= '0;
        end else cnt <= CW'(cnt - 1);
        RX_DATA: if (cnt == '0) begin
          rx_byte <= {rxd_s2, rx_byte[7:1]};
          cnt     <= CW'(CLKS_PER_BIT - 1);
          bit_idx <= 3'(bit_idx + 1);
          if (bit_idx == 3'd7) rx_state <= RX_STOP;
        end else cnt <= CW'(cnt - 1);
        RX_STOP: if (cnt == '0) begin
          byte_valid <= rxd_s2;
          frame_err  <= !rxd_s2;
          rx_state   <= RX_IDLE;
        end else cnt <= CW'(cnt - 1);
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  state_t       state;
  logic [7:0]   len_hi;
  logic [15:0]  len;
  logic [1:0]   byte_cnt;
  logic [23:0]  word_sr;
  logic [16:0]  words_ext, len_ext;
`ifdef LOADER_CSUM_EN
  logic [7:0]   csum;
`endif

  assign words_ext = 17'(words_loaded);
  assign len_ext   = {1'b0, len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cpu_hold        <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_code        <= '0;
      words_loaded    <= '0;
      len_hi          <= '0;
      len             <= '0;
      byte_cnt        <= '0;
      word_sr         <= '0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
`ifdef LOADER_CSUM_EN
      csum            <= '0;
`endif
    end else begin
      imem.imem_we <= 1'b0;
      if (start) begin
        // Restart from any state; a byte arriving in this same cycle is dropped.
        state          <= S_LEN_HI;
        cpu_hold       <= 1'b1;
        done           <= 1'b0;
        err            <= 1'b0;
        err_code       <= '0;
        words_loaded   <= '0;
        byte_cnt       <= '0;
        imem.imem_addr <= '0;
`ifdef LOADER_CSUM_EN
        csum           <= '0;
`endif
      end else if (frame_err && state != S_IDLE && state != S_DONE) begin
        state    <= S_ERROR;
        cpu_hold <= 1'b1;
        err      <= 1'b1;
        err_code <= ERR_FRAME;
      end else begin
        case (state)
          S_LEN_HI: if (byte_valid) begin
            len_hi <= rx_byte;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: if (byte_valid) begin
            len <= {len_hi, rx_byte};
            if ({len_hi, rx_byte} != 16'd0 && {1'b0, len_hi, rx_byte} <= MAX_LEN) begin
              state <= S_DATA;
            end else begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end
          end
          S_DATA: if (byte_valid) begin
            byte_cnt <= 2'(byte_cnt + 1);
            word_sr  <= {word_sr[15:0], rx_byte};
`ifdef LOADER_CSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            if (byte_cnt == 2'd3) begin
              imem.imem_we    <= 1'b1;
              imem.imem_addr  <= words_loaded[ADDR_W-1:0];
              imem.imem_wdata <= {word_sr, rx_byte};
              words_loaded    <= (ADDR_W+1)'(words_loaded + 1);
`ifdef LOADER_CSUM_EN
              if (words_ext + 17'd1 == len_ext) state <= S_CSUM;
`endif
            end
          end
`ifndef LOADER_CSUM_EN
          // Without a checksum the load completes the cycle after the final write.
          else if (imem.imem_we && words_ext == len_ext) begin
            state    <= S_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
`endif
`ifdef LOADER_CSUM_EN
          S_CSUM: if (byte_valid) begin
            if (rx_byte == csum) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
`endif
          default: ;  // IDLE, DONE and ERROR discard received bytes
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: IMEM writes are scoreboarded against a queue
// filled as each word is transmitted; end-of-load status is asserted after each scenario.
module tb_uart_imem_loader;

  localparam int CPB    = 8;
  localparam int ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rxd;
  logic            start;
  logic            cpu_hold, done, err;
  logic [1:0]      err_code;
  logic [ADDR_W:0] words_loaded;

  int   checks   = 0;
  int   failures = 0;
  int   wr_count = 0;
  int   bv_count = 0;
  wr_t  exp_q[$];
  logic [7:0] tb_csum;

  uart_imem_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .start        (start),
    .imem         (imem_bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_bus.imem_we === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(imem_bus.imem_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_bus.imem_addr), 32'(e.addr));
        check("wr_data", imem_bus.imem_wdata, e.data);
      end
    end
    if (dut.byte_valid === 1'b1) bv_count++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tb_csum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk) rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w);
    logic [7:0] b;
    exp_q.push_back('{addr: addr, data: w});
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      tb_csum = tb_csum ^ b;
      send_byte(b, 1'b0);
    end
  endtask

  task automatic send_csum(input bit corrupt);
`ifdef LOADER_CSUM_EN
    send_byte(corrupt ? 8'h00 : tb_csum, 1'b0);
`else
    if (corrupt) tb_csum = 8'h00;
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hold"},  32'(cpu_hold), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_code"},  32'(err_code), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_we"},    32'(imem_bus.imem_we), 32'd0);
  endtask

  task automatic nominal_load(input string tag);
    int w0;
    w0 = wr_count;
    pulse_start();
    check({tag, "_hold_rise"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done_clr"},  32'(done), 32'd0);
    send_len(16'd2);
    send_word(10'd0, 32'h2408_0005);
    send_word(10'd1, 32'h0000_000C);
    send_csum(1'b0);
    settle(20);
    check({tag, "_done"},   32'(done), 32'd1);
    check({tag, "_hold"},   32'(cpu_hold), 32'd0);
    check({tag, "_err"},    32'(err), 32'd0);
    check({tag, "_words"},  32'(words_loaded), 32'd2);
    check({tag, "_writes"}, 32'(wr_count - w0), 32'd2);
    check({tag, "_pend"},   32'(exp_q.size()), 32'd0);
  endtask

  task automatic bad_len(input logic [15:0] n, input string tag);
    int w0;
    w0 = wr_count;
    pulse_start();
    send_len(n);
    settle(20);
    check({tag, "_err"},    32'(err), 32'd1);
    check({tag, "_code"},   32'(err_code), 32'd2);
    check({tag, "_hold"},   32'(cpu_hold), 32'd1);
    check({tag, "_writes"}, 32'(wr_count - w0), 32'd0);
  endtask

  initial begin
    int w0, bv0;
    rst_n = 1'b0;
    rxd   = 1'b1;
    start = 1'b0;
    tb_csum = 8'h00;
    settle(5);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    settle(5);

    nominal_load("nominal");

`ifdef LOADER_CSUM_EN
    w0 = wr_count;
    pulse_start();
    send_len(16'd2);
    send_word(10'd0, 32'h2408_0005);
    send_word(10'd1, 32'h0000_000C);
    send_csum(1'b1);
    settle(20);
    check("badcsum_err",    32'(err), 32'd1);
    check("badcsum_code",   32'(err_code), 32'd3);
    check("badcsum_hold",   32'(cpu_hold), 32'd1);
    check("badcsum_done",   32'(done), 32'd0);
    check("badcsum_writes", 32'(wr_count - w0), 32'd2);
`endif

    bad_len(16'h0000, "len_zero");
    bad_len(16'h0401, "len_1025");

    // Framing error on the third data byte.
    w0 = wr_count;
    pulse_start();
    send_len(16'd2);
    send_byte(8'h24, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b1);
    settle(20);
    check("frame_err",    32'(err), 32'd1);
    check("frame_code",   32'(err_code), 32'd1);
    check("frame_hold",   32'(cpu_hold), 32'd1);
    check("frame_writes", 32'(wr_count - w0), 32'd0);
    nominal_load("recover");

    // Abort after six bytes, then a one-word load.
    w0 = wr_count;
    pulse_start();
    send_len(16'd2);
    send_word(10'd0, 32'h1122_3344);
    settle(3);
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'hDEAD_BEEF);
    send_csum(1'b0);
    settle(20);
    check("abort_done",   32'(done), 32'd1);
    check("abort_hold",   32'(cpu_hold), 32'd0);
    check("abort_words",  32'(words_loaded), 32'd1);
    check("abort_writes", 32'(wr_count - w0), 32'd2);
    check("abort_pend",   32'(exp_q.size()), 32'd0);

    // Reset mid-load, then a short glitch on the line.
    pulse_start();
    send_len(16'd2);
    send_word(10'd0, 32'hCAFE_F00D);
    settle(3);
    check("pre_rst_hold", 32'(cpu_hold), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("in_rst");
    settle(3);
    rst_n = 1'b1;
    settle(3);
    check_idle_outputs("post_rst");
    bv0 = bv_count;
    w0  = wr_count;
    rxd = 1'b0;
    settle(2);
    rxd = 1'b1;
    settle(15 * CPB);
    check("glitch_bytes",  32'(bv_count - bv0), 32'd0);
    check("glitch_writes", 32'(wr_count - w0), 32'd0);
    check_idle_outputs("glitch");
    check("final_pend", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
